// File: rtl/mem_stage_if.sv
// EXE/MEM inputs and MEM/WB outputs of the memory stage.
// The master modport is the execute side; the slave modport is mem_stage.
interface mem_stage_if;
  logic [31:0] pc_in;
  logic        wb_en;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] ALU_result;
  logic [31:0] st_value;
  logic [4:0]  dest;
  logic [31:0] pc_out;
  logic        wb_en_out;
  logic        mem_read_out;
  logic [31:0] ALU_result_out;
  logic [31:0] mem_data;
  logic [4:0]  dest_out;
  logic        stall;

  modport master (
    output pc_in, wb_en, mem_read, mem_write,
    output ALU_result, st_value, dest,
    input  pc_out, wb_en_out, mem_read_out,
    input  ALU_result_out, mem_data, dest_out,
    input  stall
  );

  modport slave (
    input  pc_in, wb_en, mem_read, mem_write,
    input  ALU_result, st_value, dest,
    output pc_out, wb_en_out, mem_read_out,
    output ALU_result_out, mem_data, dest_out,
    output stall
  );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: EXE/MEM register, multi-cycle data RAM, MEM/WB register.
// Upstream is stalled while a load or store occupies the stage.
module mem_stage #(
  parameter int          DEPTH_LOG2  = 8,
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          MEM_LATENCY = 2
) (
  input logic       clk,
  input logic       rst,
  mem_stage_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_LATENCY - 1);
  localparam logic [31:0] SPAN = 32'(DEPTH * 4);

  typedef struct packed {
    logic [31:0] pc;
    logic        wb_en;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] alu;
    logic [31:0] st_value;
    logic [4:0]  dest;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        wb_en;
    logic        mem_read;
    logic [31:0] alu;
    logic [31:0] data;
    logic [4:0]  dest;
  } mem_wb_t;

  ex_mem_t l_q;
  mem_wb_t o_q;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  logic [31:0] ram [DEPTH];

  logic                  memop;
  logic                  stall;
  logic [31:0]           off;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]           rd_data;

  assign memop    = l_q.mem_read | l_q.mem_write;
  assign stall    = memop && (cnt_q != LAST);
  assign off      = l_q.alu - BASE_ADDR;
  assign in_range = off < SPAN;
  assign idx      = off[DEPTH_LOG2+1:2];
  assign rd_data  = (l_q.mem_read && in_range) ? ram[idx] : 32'd0;

  // Access counter: advance while stalled, restart when the access completes.
  always_comb begin
    cnt_d = '0;
    if (stall) cnt_d = cnt_q + CW'(1);
  end

  // Access counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  // EXE/MEM register: frozen while the stage is busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      l_q <= '0;
    end else if (!stall) begin
      l_q.pc        <= bus.pc_in;
      l_q.wb_en     <= bus.wb_en;
      l_q.mem_read  <= bus.mem_read;
      l_q.mem_write <= bus.mem_write;
      l_q.alu       <= bus.ALU_result;
      l_q.st_value  <= bus.st_value;
      l_q.dest      <= bus.dest;
    end
  end

  // Data RAM: stores commit only on the completing edge and only in range.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
    end else if (!stall && l_q.mem_write && in_range) begin
      ram[idx] <= l_q.st_value;
    end
  end

  // MEM/WB register: result on completion, bubble while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_q <= '0;
    end else if (stall) begin
      o_q <= '0;
    end else begin
      o_q.pc       <= l_q.pc;
      o_q.wb_en    <= l_q.wb_en;
      o_q.mem_read <= l_q.mem_read;
      o_q.alu      <= l_q.alu;
      o_q.data     <= rd_data;
      o_q.dest     <= l_q.dest;
    end
  end

  assign bus.pc_out         = o_q.pc;
  assign bus.wb_en_out      = o_q.wb_en;
  assign bus.mem_read_out   = o_q.mem_read;
  assign bus.ALU_result_out = o_q.alu;
  assign bus.mem_data       = o_q.data;
  assign bus.dest_out       = o_q.dest;
  assign bus.stall          = stall;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage at latencies 2, 4 and 1 against a word-array model.
// Directed plan steps followed by randomized load/store/ALU traffic.
module tb_mem_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        rst_a [3];
  logic [31:0] pc_a  [3];
  logic [31:0] alu_a [3];
  logic [31:0] st_a  [3];
  logic        wb_a  [3];
  logic        rd_a  [3];
  logic        wr_a  [3];
  logic [4:0]  dst_a [3];

  logic [31:0] pco   [3];
  logic [31:0] aluo  [3];
  logic [31:0] md    [3];
  logic        wbo   [3];
  logic        rdo   [3];
  logic        stl   [3];
  logic [4:0]  dsto  [3];

  logic [31:0] mram [3][256];
  int lat [3] = '{2, 4, 1};

  mem_stage_if bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 4 : 1);
    mem_stage #(.DEPTH_LOG2(8), .BASE_ADDR(32'd1024), .MEM_LATENCY(L)) u_dut (
      .clk (clk),
      .rst (rst_a[g]),
      .bus (bus[g])
    );
    assign bus[g].pc_in      = pc_a[g];
    assign bus[g].wb_en      = wb_a[g];
    assign bus[g].mem_read   = rd_a[g];
    assign bus[g].mem_write  = wr_a[g];
    assign bus[g].ALU_result = alu_a[g];
    assign bus[g].st_value   = st_a[g];
    assign bus[g].dest       = dst_a[g];
    assign pco[g]  = bus[g].pc_out;
    assign wbo[g]  = bus[g].wb_en_out;
    assign rdo[g]  = bus[g].mem_read_out;
    assign aluo[g] = bus[g].ALU_result_out;
    assign md[g]   = bus[g].mem_data;
    assign dsto[g] = bus[g].dest_out;
    assign stl[g]  = bus[g].stall;
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] st;
    logic [31:0] md;
    logic        wb;
    logic        rd;
    logic        wr;
    logic [4:0]  dst;
  } op_t;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Word-array reference: returns load data, applies the store afterwards.
  function automatic logic [31:0] model(input int d, input logic rd,
                                        input logic wr,
                                        input logic [31:0] alu,
                                        input logic [31:0] st);
    logic [31:0] off;
    logic [31:0] v;
    off = alu - 32'd1024;
    v = 32'd0;
    if (off < 32'd1024) begin
      if (rd) v = mram[d][off[9:2]];
      if (wr) mram[d][off[9:2]] = st;
    end
    return v;
  endfunction

  task automatic drive(input int d, input logic [31:0] pc, input logic wb,
                       input logic rd, input logic wr,
                       input logic [31:0] alu, input logic [31:0] st,
                       input logic [4:0] dst);
    pc_a[d] = pc;
    wb_a[d] = wb;
    rd_a[d] = rd;
    wr_a[d] = wr;
    alu_a[d] = alu;
    st_a[d] = st;
    dst_a[d] = dst;
  endtask

  task automatic chk_zero(input int d, input string tag);
    chk({tag, "_stall"}, 32'(stl[d]), 32'd0);
    chk({tag, "_wb"}, 32'(wbo[d]), 32'd0);
    chk({tag, "_pc"}, pco[d], 32'd0);
    chk({tag, "_alu"}, aluo[d], 32'd0);
    chk({tag, "_md"}, md[d], 32'd0);
    chk({tag, "_dst"}, 32'(dsto[d]), 32'd0);
  endtask

  // One instruction followed by a NOP; called and returns at a negedge.
  task automatic issue(input int d, input logic [31:0] pc, input logic wb,
                       input logic rd, input logic wr,
                       input logic [31:0] alu, input logic [31:0] st,
                       input logic [4:0] dst);
    logic [31:0] exp;
    exp = model(d, rd, wr, alu, st);
    drive(d, pc, wb, rd, wr, alu, st, dst);
    @(posedge clk);
    @(negedge clk);
    if (rd || wr) begin
      for (int k = 0; k < lat[d] - 1; k++) begin
        chk("stall_hi", 32'(stl[d]), 32'd1);
        drive(d, $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
              $urandom, $urandom, 5'($urandom));
        @(posedge clk);
        @(negedge clk);
        chk("bubble_wb", 32'(wbo[d]), 32'd0);
      end
    end
    chk("stall_lo", 32'(stl[d]), 32'd0);
    drive(d, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    @(posedge clk);
    @(negedge clk);
    chk("pc_out", pco[d], pc);
    chk("wb_out", 32'(wbo[d]), 32'(wb));
    chk("rd_out", 32'(rdo[d]), 32'(rd));
    chk("alu_out", aluo[d], alu);
    chk("dst_out", 32'(dsto[d]), 32'(dst));
    chk("mem_data", md[d], exp);
  endtask

  function automatic logic [31:0] rand_addr();
    int s;
    s = $urandom_range(0, 6);
    if (s == 0) return $urandom;
    if (s == 1) return ($urandom_range(0, 1) != 0) ? 32'd2044 : 32'd2048;
    if (s == 2) return 32'd1023;
    return 32'd1024 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
  endfunction

  op_t ops [12];

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_a[d] = 1'b0;
      drive(d, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      for (int w = 0; w < 256; w++) mram[d][w] = 32'd0;
    end

    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) chk_zero(d, "reset");
    for (int d = 0; d < 3; d++) rst_a[d] = 1'b1;

    issue(0, 32'h10, 1'b1, 1'b1, 1'b0, 32'd1024, 32'd0, 5'd3);

    issue(0, 32'h20, 1'b1, 1'b0, 1'b0, 32'h1234, 32'd0, 5'd5);

    issue(0, 32'h24, 1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 5'd0);
    issue(0, 32'h28, 1'b1, 1'b1, 1'b0, 32'd1028, 32'd0, 5'd7);

    issue(0, 32'h2c, 1'b0, 1'b0, 1'b1, 32'd0, 32'h55, 5'd0);
    issue(0, 32'h30, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 5'd8);
    issue(0, 32'h34, 1'b1, 1'b1, 1'b0, 32'd2048, 32'd0, 5'd9);
    issue(0, 32'h38, 1'b1, 1'b1, 1'b0, 32'd1024, 32'd0, 5'd10);

    issue(1, 32'h50, 1'b0, 1'b0, 1'b1, 32'd1036, 32'h99, 5'd0);
    drive(1, 32'h40, 1'b0, 1'b0, 1'b1, 32'd1032, 32'h77, 5'd0);
    @(posedge clk);
    @(negedge clk);
    chk("l4_stall_before_rst", 32'(stl[1]), 32'd1);
    @(posedge clk);
    #2;
    rst_a[1] = 1'b0;
    #1;
    chk_zero(1, "rst_mid");
    for (int w = 0; w < 256; w++) mram[1][w] = 32'd0;
    drive(1, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    rst_a[1] = 1'b1;
    issue(1, 32'h44, 1'b1, 1'b1, 1'b0, 32'd1032, 32'd0, 5'd11);
    issue(1, 32'h48, 1'b1, 1'b1, 1'b0, 32'd1036, 32'd0, 5'd12);

    for (int i = 0; i < 12; i++) begin
      ops[i].pc  = 32'h100 + 32'(4 * i);
      ops[i].alu = 32'd1024 + 32'(4 * (i / 2));
      ops[i].st  = $urandom;
      ops[i].wb  = i[0];
      ops[i].rd  = i[0];
      ops[i].wr  = ~i[0];
      ops[i].dst = 5'(i);
      if (i >= 10) begin
        ops[i].alu = 32'd0;
        ops[i].wb  = 1'b0;
        ops[i].rd  = 1'b0;
        ops[i].wr  = 1'b0;
        ops[i].dst = 5'd0;
      end
      ops[i].md = model(2, ops[i].rd, ops[i].wr, ops[i].alu, ops[i].st);
    end
    for (int i = 0; i < 12; i++) begin
      chk("b2b_stall", 32'(stl[2]), 32'd0);
      if (i >= 2) begin
        chk("b2b_pc", pco[2], ops[i-2].pc);
        chk("b2b_wb", 32'(wbo[2]), 32'(ops[i-2].wb));
        chk("b2b_rd", 32'(rdo[2]), 32'(ops[i-2].rd));
        chk("b2b_dst", 32'(dsto[2]), 32'(ops[i-2].dst));
        chk("b2b_md", md[2], ops[i-2].md);
      end
      drive(2, ops[i].pc, ops[i].wb, ops[i].rd, ops[i].wr,
            ops[i].alu, ops[i].st, ops[i].dst);
      @(posedge clk);
      @(negedge clk);
    end

    for (int n = 0; n < 25; n++) begin
      for (int d = 0; d < 3; d++) begin
        issue(d, $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
              rand_addr(), $urandom, 5'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
